// File: rtl/lsu_pkg.sv
// Shared types, byte-control codes and alignment helper for the load/store controller.
package lsu_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned BC_W   = 4;

   localparam logic [BC_W-1:0] BC_WORD = 4'b1111;
   localparam logic [BC_W-1:0] BC_HALF = 4'b0011;
   localparam logic [BC_W-1:0] BC_BYTE = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   // Access context held for the load-data return path.
   typedef struct packed {
      logic [BC_W-1:0] byte_ctrl;
      logic            uns;
      logic [1:0]      addr_lo;
   } lsu_ctx_t;

   // Unknown byte-control codes are treated as word accesses.
   function automatic logic is_misaligned(input logic [BC_W-1:0] bc, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (bc == BC_BYTE) begin
         mis = 1'b0;
      end else if (bc == BC_HALF) begin
         mis = addr_lo[0];
      end else begin
         mis = (addr_lo != 2'b00);
      end
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, replicated store data, shifted/extended load data.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [BC_W-1:0]   byte_ctrl,
   input  logic [1:0]        addr_lo,
   input  logic              uns,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] wdata_rep,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [DATA_W-1:0] shifted;

   always_comb begin
      shifted   = rdata >> {addr_lo, 3'b000};
      be        = '0;
      wdata_rep = '0;
      rdata_ext = '0;
      case (byte_ctrl)
         BC_BYTE: begin
            be        = BE_W'(4'b0001 << addr_lo);
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{shifted[7] & ~uns}}, shifted[7:0]};
         end
         BC_HALF: begin
            be        = BE_W'(4'b0011 << {addr_lo[1], 1'b0});
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{shifted[15] & ~uns}}, shifted[15:0]};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata_ext = shifted;
         end
      endcase
   end

endmodule

// File: rtl/load_store_ctrl.sv
// MEM-stage load/store sequencer with req/ack memory handshake and ack timeout.
// Define LSU_UNSIGNED_EN to honour req_unsigned (LBU/LHU zero-extension).
module load_store_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [BC_W-1:0]   req_byte_ctrl,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_misalign,
   output logic              rsp_timeout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

`ifdef LSU_UNSIGNED_EN
   localparam logic UNS_EN = 1'b1;
`else
   localparam logic UNS_EN = 1'b0;
`endif

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   lsu_ctx_t          ctx_q, ctx_d;

   logic              ready_d, rsp_valid_d, rsp_misalign_d, rsp_timeout_d;
   logic [DATA_W-1:0] rsp_rdata_d;
   logic              mem_req_d, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [BE_W-1:0]   mem_be_d;
   logic [DATA_W-1:0] mem_wdata_d;

   logic              uns_in;
   logic              idle_c;
   logic              timeout_hit_c;
   logic [BC_W-1:0]   lane_bc;
   logic [1:0]        lane_addr_lo;
   logic              lane_uns;
   logic [BE_W-1:0]   lane_be;
   logic [DATA_W-1:0] lane_wdata_rep;
   logic [DATA_W-1:0] lane_rdata_ext;

   assign uns_in = req_unsigned & UNS_EN;
   assign idle_c = (state_q == IDLE);

   // In IDLE the aligner steers the incoming request; afterwards it serves the held access.
   assign lane_bc      = idle_c ? req_byte_ctrl : ctx_q.byte_ctrl;
   assign lane_addr_lo = idle_c ? req_addr[1:0] : ctx_q.addr_lo;
   assign lane_uns     = idle_c ? uns_in        : ctx_q.uns;

   assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                          ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

   lsu_lane_align u_lane_align (
      .byte_ctrl (lane_bc),
      .addr_lo   (lane_addr_lo),
      .uns       (lane_uns),
      .wdata     (req_wdata),
      .rdata     (mem_rdata),
      .be        (lane_be),
      .wdata_rep (lane_wdata_rep),
      .rdata_ext (lane_rdata_ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ctx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ctx_q   <= ctx_d;
      end
   end

   // Next state, counter and next values of every registered output.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      ctx_d          = ctx_q;
      ready_d        = 1'b0;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = rsp_rdata;
      rsp_misalign_d = rsp_misalign;
      rsp_timeout_d  = rsp_timeout;
      mem_req_d      = 1'b0;
      mem_we_d       = 1'b0;
      mem_addr_d     = '0;
      mem_be_d       = '0;
      mem_wdata_d    = '0;

      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            cnt_d   = '0;
            if (req_valid) begin
               ready_d       = 1'b0;
               ctx_d.byte_ctrl = req_byte_ctrl;
               ctx_d.uns     = uns_in;
               ctx_d.addr_lo = req_addr[1:0];
               if (is_misaligned(req_byte_ctrl, req_addr[1:0])) begin
                  state_d        = RESP;
                  rsp_valid_d    = 1'b1;
                  rsp_rdata_d    = '0;
                  rsp_misalign_d = 1'b1;
                  rsp_timeout_d  = 1'b0;
               end else begin
                  state_d     = BUSY;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                  mem_be_d    = lane_be;
                  mem_wdata_d = lane_wdata_rep;
               end
            end
         end
         BUSY: begin
            mem_req_d   = 1'b1;
            mem_we_d    = mem_we;
            mem_addr_d  = mem_addr;
            mem_be_d    = mem_be;
            mem_wdata_d = mem_wdata;
            // Ack takes priority over a timeout expiring in the same cycle.
            if (mem_ack) begin
               state_d        = RESP;
               cnt_d          = '0;
               rsp_valid_d    = 1'b1;
               rsp_rdata_d    = mem_we ? '0 : lane_rdata_ext;
               rsp_misalign_d = 1'b0;
               rsp_timeout_d  = 1'b0;
            end else if (timeout_hit_c) begin
               state_d        = RESP;
               cnt_d          = '0;
               rsp_valid_d    = 1'b1;
               rsp_rdata_d    = '0;
               rsp_misalign_d = 1'b0;
               rsp_timeout_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (state_d == RESP) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_be_d    = '0;
               mem_wdata_d = '0;
            end
         end
         RESP: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_misalign <= 1'b0;
         rsp_timeout  <= 1'b0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
      end else begin
         req_ready    <= ready_d;
         rsp_valid    <= rsp_valid_d;
         rsp_rdata    <= rsp_rdata_d;
         rsp_misalign <= rsp_misalign_d;
         rsp_timeout  <= rsp_timeout_d;
         mem_req      <= mem_req_d;
         mem_we       <= mem_we_d;
         mem_addr     <= mem_addr_d;
         mem_be       <= mem_be_d;
         mem_wdata    <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Scoreboard bench for load_store_ctrl (TIMEOUT_CYCLES=4); honours LSU_UNSIGNED_EN.
module tb_load_store_ctrl;

   localparam logic [3:0] B_WORD = 4'b1111;
   localparam logic [3:0] B_HALF = 4'b0011;
   localparam logic [3:0] B_BYTE = 4'b0001;

`ifdef LSU_UNSIGNED_EN
   localparam bit UNS_EN = 1'b1;
`else
   localparam bit UNS_EN = 1'b0;
`endif

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [3:0]  req_byte_ctrl;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_misalign, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   load_store_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_byte_ctrl(req_byte_ctrl), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misalign(rsp_misalign), .rsp_timeout(rsp_timeout),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   // Reference model built lane by lane from the access size and offset.
   function automatic void model(input logic [3:0] bc, input logic [31:0] addr, input logic uns,
                                 input logic [31:0] wd, input logic [31:0] rd,
                                 output logic [3:0] be, output logic [31:0] wrep,
                                 output logic [31:0] rext, output logic mis);
      int size, off;
      size = (bc == B_BYTE) ? 1 : (bc == B_HALF) ? 2 : 4;
      off  = int'(addr[1:0]);
      if (size == 4) off = 0;
      else if (size == 2) off = off & 2;
      mis  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
      be = '0; wrep = '0; rext = '0;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + size) be[i] = 1'b1;
         wrep[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      for (int j = 0; j < size; j++) rext[8*j +: 8] = rd[8*(off + j) +: 8];
      if (size < 4 && !(uns && UNS_EN) && rext[8*size-1])
         for (int j = size; j < 4; j++) rext[8*j +: 8] = 8'hFF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access: push expectation, accept, play memory, then pop and compare the response.
   task automatic access(input logic we, input logic [3:0] bc, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int ack_delay, input int exp_cycles, input logic exp_to);
      logic [3:0]  ebe;
      logic [31:0] ewr, erx;
      logic        emis;
      exp_t        e, got_e;
      int          lat, nreq;
      bit          got;
      model(bc, addr, uns, wd, rd, ebe, ewr, erx, emis);
      e.mis   = emis;
      e.to    = emis ? 1'b0 : exp_to;
      e.rdata = (we || emis || exp_to) ? 32'h0 : erx;
      sb.push_back(e);
      for (int i = 0; i < 20 && !req_ready; i++) tick();
      check("req_ready_before_accept", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_byte_ctrl = bc; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      tick();
      req_valid = 1'b0;
      got = 0; lat = -1; nreq = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (rsp_valid) begin
            got = 1; lat = k;
         end else begin
            nreq += int'(mem_req);
            check("mem_req_busy", mem_req, !emis);
            check("mem_addr", mem_addr, {addr[31:2], 2'b00});
            check("mem_be", mem_be, ebe);
            check("mem_we", mem_we, we);
            if (we) check("mem_wdata", mem_wdata, ewr);
            mem_rdata = $urandom;
            if (k == ack_delay) begin
               mem_ack = 1'b1; mem_rdata = rd;
            end
            req_valid = k[0]; req_addr = $urandom; req_we = ~we; req_byte_ctrl = $urandom;
            tick();
            mem_ack = 1'b0;
         end
      end
      req_valid = 1'b0;
      got_e = sb.pop_front();
      if (!got) begin
         check("rsp_wait_expired", 0, 1);
      end else begin
         check("rsp_rdata", rsp_rdata, got_e.rdata);
         check("rsp_misalign", rsp_misalign, got_e.mis);
         check("rsp_timeout", rsp_timeout, got_e.to);
         check("rsp_latency", lat, emis ? 0 : exp_cycles);
         check("mem_req_cycles", nreq, emis ? 0 : exp_cycles);
         check("mem_req_in_resp", mem_req, 0);
         check("ready_in_resp", req_ready, 0);
      end
      tick();
      check("rsp_valid_pulse", rsp_valid, 0);
      check("ready_after_resp", req_ready, 1);
      check("rsp_hold", rsp_rdata, got_e.rdata);
   endtask

   initial begin
      logic [3:0] bc;
      int         d;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte_ctrl = '0; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      #12;
      check("reset_ready", req_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_mem_req", mem_req, 0);
      check("reset_rsp_rdata", rsp_rdata, 0);
      check("reset_mem_be", mem_be, 0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // Directed cases; the explicit constants double-check the model.
      access(1, B_BYTE, 0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1, 0);
      access(0, B_HALF, 0, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 2, 0);
      check("half_signed_const", rsp_rdata, 32'hFFFF_8001);
      access(0, B_HALF, 1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1, 0);
      check("half_unsigned_const", rsp_rdata, UNS_EN ? 32'h0000_8001 : 32'hFFFF_8001);
      access(0, B_WORD, 0, 32'h0000_3001, 32'h0, 32'h0, 0, 1, 0);
      check("misalign_const", {rsp_misalign, rsp_rdata[3:0]}, 5'b1_0000);
      access(0, B_HALF, 0, 32'h0000_2001, 32'h0, 32'h0, 0, 1, 0);
      access(1, B_HALF, 0, 32'h0000_4002, 32'h1234_BEEF, 32'h0, 3, 4, 0);
      access(0, B_BYTE, 1, 32'h0000_5001, 32'h0, 32'h1234_F600, 2, 3, 0);
      access(0, B_WORD, 0, 32'h0000_6000, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
      access(0, 4'b0111, 0, 32'h0000_7002, 32'h0, 32'h0, 0, 1, 0);
      access(1, 4'b0101, 0, 32'h0000_7004, 32'hCAFE_F00D, 32'h0, 1, 2, 0);
      access(0, B_WORD, 0, 32'h0000_9000, 32'h0, 32'h0, -1, 4, 1);
      check("timeout_const", rsp_timeout, 1);

      // Ack outside BUSY must be ignored.
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      check("idle_ack_rsp", rsp_valid, 0);
      check("idle_ack_memreq", mem_req, 0);
      check("idle_ack_ready", req_ready, 1);

      for (int n = 0; n < 24; n++) begin
         case ($urandom_range(0, 3))
            0: bc = B_BYTE;
            1: bc = B_HALF;
            2: bc = B_WORD;
            default: bc = 4'($urandom);
         endcase
         d = $urandom_range(0, 3);
         access(1'($urandom), bc, 1'($urandom), $urandom, $urandom, $urandom, d, d + 1, 0);
      end

      // Asynchronous reset in the middle of an access.
      req_valid = 1'b1; req_we = 1'b0; req_byte_ctrl = B_WORD; req_addr = 32'h0000_8000;
      tick();
      req_valid = 1'b0;
      tick();
      check("pre_reset_mem_req", mem_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_mem_req", mem_req, 0);
      check("async_reset_rsp_valid", rsp_valid, 0);
      check("async_reset_ready", req_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      tick();
      access(0, B_BYTE, 0, 32'h0000_8003, 32'h0, 32'h7F00_0000, 1, 2, 0);
      check("post_reset_load", rsp_rdata, 32'h0000_007F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
